// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by the VGA sync generator and its counters.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FP_DEF      = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BP_DEF      = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;

   localparam int H_TOTAL      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START = H_VISIBLE_DEF + H_FP_DEF;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
   localparam int V_SYNC_START = V_VISIBLE_DEF + V_FP_DEF;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-N raster axis counter with enable; wrap marks the enabled step from N-1 back to 0.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int N = H_TOTAL
) (
   input  logic   clk_d,
   input  logic   rst,
   input  logic   en,
   output coord_t cnt,
   output coord_t cnt_next,
   output logic   wrap
);

   localparam coord_t LAST = coord_t'(N - 1);

   assign wrap = en && (cnt == LAST);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cnt_next = cnt;
      if (en) begin
         cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // NOTE: reset is synchronous, so rst is tested inside the clocked block and
   // state is updated with non-blocking assignments only.
   always_ff @(posedge clk_d) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster/sync generator for the display clock domain (clk_d).
// Define VGA_CLK_DIV_EN to advance the raster once every CLK_DIV clk_d cycles.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF,
   parameter int CLK_DIV   = 4
) (
   input  logic               clk_d,
   input  logic               rst,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               video_on,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start,
   output logic               pix_tick
);

   localparam int     H_TOT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int     V_TOT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
   localparam coord_t H_SS   = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t H_SE   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t V_SS   = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t V_SE   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be 2 or more");
   end

`ifdef VGA_CLK_DIV_EN
   localparam int                 DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk_d) begin
      if (rst || pix_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign pix_tick = (div_cnt == DIV_LAST);
`else
   assign pix_tick = 1'b1;
`endif

   coord_t h_next;
   coord_t v_next;
   logic   h_wrap;
   logic   v_wrap;

   vga_axis_counter #(.N(H_TOT)) u_h_cnt (
      .clk_d    (clk_d),
      .rst      (rst),
      .en       (pix_tick),
      .cnt      (pixel_x),
      .cnt_next (h_next),
      .wrap     (h_wrap)
   );

   vga_axis_counter #(.N(V_TOT)) u_v_cnt (
      .clk_d    (clk_d),
      .rst      (rst),
      .en       (h_wrap),
      .cnt      (pixel_y),
      .cnt_next (v_next),
      .wrap     (v_wrap)
   );

   // Decodes look at the next-count values so they land on the same edge as
   // pixel_x/pixel_y; frame_start is never held, so it stays one clk_d wide.
   always_ff @(posedge clk_d) begin
      if (rst) begin
         video_on    <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= v_wrap;
         if (pix_tick) begin
            video_on <= (h_next < H_VIS) && (v_next < V_VIS);
            hsync    <= !((h_next >= H_SS) && (h_next < H_SE));
            vsync    <= !((v_next >= V_SS) && (v_next < V_SE));
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: per-cycle scoreboard plus table-driven checkpoints.
// Uses the real horizontal timing and a short 15-line frame to keep runs brief.
module tb_vga_sync_gen;

   localparam int HV = 640, HF = 16, HS = 96, HB = 48;
   localparam int VV = 8,   VF = 2,  VS = 2,  VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int CLK_DIV = 4;

   logic       clk_d = 1'b0;
   logic       rst   = 1'b1;
   logic [9:0] pixel_x, pixel_y;
   logic       video_on, hsync, vsync, frame_start, pix_tick;

   vga_sync_gen #(
      .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .CLK_DIV   (CLK_DIV)
   ) dut (
      .clk_d       (clk_d),
      .rst         (rst),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .video_on    (video_on),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .pix_tick    (pix_tick)
   );

   always #5 clk_d = ~clk_d;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vo;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       pt;
   } obs_t;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic obs_t cur_obs();
      return '{x: pixel_x, y: pixel_y, vo: video_on, hs: hsync, vs: vsync,
               fs: frame_start, pt: pix_tick};
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got x=%0d y=%0d vo=%b hs=%b vs=%b fs=%b pt=%b, expected x=%0d y=%0d vo=%b hs=%b vs=%b fs=%b pt=%b",
                  name, $time, act.x, act.y, act.vo, act.hs, act.vs, act.fs, act.pt,
                  exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.fs, exp.pt);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Scoreboard: a behavioural raster model pushes the expected outputs for
   // every clock edge; the DUT outputs are popped and compared half a cycle later.
   obs_t sb_q[$];
   int   mx, my, md;
   bit   m_valid = 1'b0;
   obs_t m_out;

   task automatic model_step();
      bit tick;
      if (rst) begin
         mx = 0; my = 0; md = 0; m_valid = 1'b1;
         m_out = '{x: 10'd0, y: 10'd0, vo: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pt: 1'b1};
`ifdef VGA_CLK_DIV_EN
         m_out.pt = 1'b0;
`endif
      end else if (m_valid) begin
`ifdef VGA_CLK_DIV_EN
         tick = (md == CLK_DIV - 1);
`else
         tick = 1'b1;
`endif
         m_out.fs = 1'b0;
         if (tick) begin
            if (mx == HT - 1) begin
               mx = 0;
               m_out.fs = (my == VT - 1);
               my = (my == VT - 1) ? 0 : my + 1;
            end else begin
               mx = mx + 1;
            end
            m_out.x  = 10'(mx);
            m_out.y  = 10'(my);
            m_out.vo = (mx < HV) && (my < VV);
            m_out.hs = !((mx >= HV + HF) && (mx < HV + HF + HS));
            m_out.vs = !((my >= VV + VF) && (my < VV + VF + VS));
         end
`ifdef VGA_CLK_DIV_EN
         md = tick ? 0 : md + 1;
         m_out.pt = (md == CLK_DIV - 1);
`endif
      end
      if (m_valid) sb_q.push_back(m_out);
   endtask

   always @(posedge clk_d) model_step();

   always @(negedge clk_d) begin
      if (sb_q.size() > 0) check_obs("scoreboard", cur_obs(), sb_q.pop_front());
   end

   task automatic step(input bit r);
      rst = r;
      @(posedge clk_d);
      @(negedge clk_d);
   endtask

   typedef struct {
      string name;
      int    rst_cyc;
      int    run;
      int    x;
      int    y;
      bit    vo;
      bit    hs;
      bit    vs;
      bit    fs;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int   cnt;
      int   hs_low, vs_low, fs_cnt, fs_pos;
      obs_t exp;

      tbl[0]  = '{"reset_hold",      5, 0,     0,   0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{"first_tick",      0, 1,     1,   0,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{"last_visible_x",  0, 638,   639, 0,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{"h_blank_start",   0, 1,     640, 0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{"hsync_start",     0, 16,    656, 0,  1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{"hsync_last",      0, 95,    751, 0,  1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{"hsync_end",       0, 1,     752, 0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{"line_end",        0, 47,    799, 0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{"line_wrap",       0, 1,     0,   1,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{"frame_end",       0, 11199, 799, 14, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{"frame_wrap",      0, 1,     0,   0,  1'b1, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{"after_wrap",      0, 1,     1,   0,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{"mid_frame_vsync", 0, 8299,  300, 10, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{"mid_frame_reset", 1, 0,     0,   0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{"tick_after_rst",  0, 1,     1,   0,  1'b1, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      @(negedge clk_d);

`ifndef VGA_CLK_DIV_EN
      foreach (tbl[i]) begin
         repeat (tbl[i].rst_cyc) step(1'b1);
         repeat (tbl[i].run) step(1'b0);
         exp = '{x: 10'(tbl[i].x), y: 10'(tbl[i].y), vo: tbl[i].vo, hs: tbl[i].hs,
                 vs: tbl[i].vs, fs: tbl[i].fs, pt: 1'b1};
         check_obs(tbl[i].name, cur_obs(), exp);
      end

      // After the mid-frame reset the next frame must be a full HT*VT ticks.
      cnt = 1;
      while (!frame_start && cnt < 2 * HT * VT) begin
         step(1'b0);
         cnt++;
      end
      check_int("frame_len_after_reset", cnt, HT * VT);

      // One full frame: sync widths and a single frame_start at the end.
      hs_low = 0; vs_low = 0; fs_cnt = 0; fs_pos = 0;
      for (int t = 1; t <= HT * VT; t++) begin
         step(1'b0);
         if (!hsync) hs_low++;
         if (!vsync) vs_low++;
         if (frame_start) begin
            fs_cnt++;
            fs_pos = t;
         end
      end
      check_int("hsync_low_ticks", hs_low, HS * VT);
      check_int("vsync_low_ticks", vs_low, VS * HT);
      check_int("frame_start_count", fs_cnt, 1);
      check_int("frame_period", fs_pos, HT * VT);
      step(1'b0);
      check_int("frame_start_width", int'(frame_start), 0);
`else
      repeat (5) step(1'b1);
      check_obs("div_reset", cur_obs(),
                '{x: 10'd0, y: 10'd0, vo: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pt: 1'b0});
      for (int k = 1; k <= 12; k++) begin
         step(1'b0);
         check_int("div_pix_tick", int'(pix_tick), int'((k % CLK_DIV) == CLK_DIV - 1));
         check_int("div_pixel_x_hold", int'(pixel_x), k / CLK_DIV);
      end
      cnt = 12;
      while (!frame_start && cnt < 2 * HT * VT * CLK_DIV) begin
         step(1'b0);
         cnt++;
      end
      check_int("div_first_frame_start", cnt, HT * VT * CLK_DIV);
      step(1'b0);
      check_int("div_frame_start_width", int'(frame_start), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Produces the raster scan that the pixel generator consumes: pixel_x, pixel_y, video_on, plus the hsync and vsync pins for the VGA connector.
- Default timing is 640x480 at 60 Hz, with an 800x525 total raster.
- Sits between the display clock domain (clk_d) and the pixel generator / snake renderer.
- Also emits a one-cycle frame_start pulse, which the game logic uses to advance the snake once per frame.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk_d cycles per pixel; only used when VGA_CLK_DIV_EN is defined; legal values are 2 or more

Ports:
- clk_d  input  1  display clock; all logic on its rising edge
- rst  input  1  reset, synchronous, active-high
- pixel_x  output  10  current horizontal count, 0..799 (raw, including blanking)
- pixel_y  output  10  current vertical count, 0..524 (raw, including blanking)
- video_on  output  1  high iff pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
- hsync  output  1  active-low horizontal sync
- vsync  output  1  active-low vertical sync
- frame_start  output  1  one-cycle pulse when the counters wrap to (0,0)
- pix_tick  output  1  high on the cycles where the counters advance

Interface decision: one clock; reset is synchronous and active-high (clk_d, rst).

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Counters: h_cnt and v_cnt, 10 bits each.
  - pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the registers.
- Advance rule, applied on each pix_tick (every clk_d cycle in the default build):
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1, v_cnt wraps to 0 in the same cycle that h_cnt wraps.
- Registered decodes: video_on, hsync, vsync and frame_start are registered and computed from the next-count values, so they change in the same cycle as pixel_x/pixel_y. There is zero skew between position and decode.
- Sync windows:
  - hsync = 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC, i.e. h_cnt in 656..751.
  - vsync = 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC, i.e. v_cnt in 490..491.
- frame_start is 1 for exactly the one clk_d cycle in which the counters hold (0,0) after a wrap.
- Reset values: h_cnt=0, v_cnt=0, video_on=0, hsync=1, vsync=1, frame_start=0.
  - In the div build the divider count is also 0 and pix_tick=0.
- First tick after reset release moves the counters to (1,0) with video_on=1. Pixel (0,0) of the first frame after reset is therefore blanked; this is by design.
- Reset asserted mid-frame: on the next edge all state returns to the reset values, with no partial sync pulse completion.
- Simultaneous wrap: h and v wrap on the same edge at (799,524) -> (0,0), with frame_start=1 on that edge.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. No other state exists.

Optional Feature:
- Macro: VGA_CLK_DIV_EN.
- Defined:
  - An internal divider counts 0..CLK_DIV-1.
  - pix_tick=1 only when the divider equals CLK_DIV-1; counters and decodes update only on those cycles.
  - Outputs hold their values between ticks.
  - frame_start is high only on the single clk_d cycle following the wrapping tick edge, not for CLK_DIV cycles.
  - This build runs directly off 100 MHz clk_d.
- Not defined: pix_tick is tied to 1, the counters advance every clk_d cycle, and CLK_DIV is ignored.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL, V_TOTAL, H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END;
  - the 10-bit coordinate width constant.
- One natural sub-module, vga_axis_counter: a mod-N counter with enable and a wrap output, instantiated twice.
  - The horizontal instance is enabled by pix_tick.
  - The vertical instance is enabled by pix_tick AND the horizontal wrap.

Test Plan:
1. Reset: hold rst for 5 cycles -> pixel_x=0, pixel_y=0, video_on=0, hsync=1, vsync=1, frame_start=0 during reset. First edge after release -> pixel_x=1, video_on=1.
2. Line timing: run one line -> video_on falls on the edge pixel_x goes 639->640. hsync=0 for exactly 96 ticks, pixel_x 656..751. pixel_x wraps 799->0 and pixel_y increments.
3. Frame timing: run 800x525 ticks -> vsync=0 only for pixel_y 490..491 (1600 ticks). video_on stays 0 for pixel_y >= 480. frame_start pulses once, at (0,0).
4. Mid-frame reset: assert rst at (300,200) for 1 cycle -> next edge gives (0,0) with outputs at reset values; the following frame has full length (420000 ticks).
5. Boundary: at (799,524) -> next edge gives (0,0) with frame_start=1, hsync=1, vsync=1, video_on=1.
6. With VGA_CLK_DIV_EN and CLK_DIV=4: pix_tick high every 4th cycle, and pixel_x holds for 4 cycles. Period between frame_start pulses is 1,680,000 clk_d cycles, and frame_start is 1 cycle wide.
